fetch_ctrl: RTL

//  Sequences the fetch-stage PC register: picks pc_nxt, drives stallpc, runs the ibus request handshake.

---
 rtl/fetch_ctrl_pkg.sv | 39 +++
 rtl/fetch_ctrl_redir_arb.sv | 39 +++
 rtl/fetch_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types for the fetch controller
//
// Holds the common scalar types (u64, u32) and the pipeline-facing types:
// fetch_state_t, redir_prio_t and redirect_t. Priority encodings are ordered
// so that a plain numeric compare answers "is this redirect more urgent".
package fetch_ctrl_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Numeric order is the arbitration order: larger value wins.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    ID   = 2'd1,
    EX   = 2'd2,
    TRAP = 2'd3
  } redir_prio_t;

  typedef struct packed {
    logic        valid;
    redir_prio_t prio;
    u64          target;
  } redirect_t;

  function automatic redirect_t no_redirect();
    redirect_t r;
    r.valid  = 1'b0;
    r.prio   = NONE;
    r.target = '0;
    return r;
  endfunction

endpackage

// File: rtl/fetch_ctrl_redir_arb.sv
// rtl/fetch_ctrl_redir_arb.sv - combinational 3-way redirect priority select
//
// Purpose: pick the most urgent of the redirect sources this cycle,
//          trap > execute mispredict > decode jump.
// Ports:
//   trap_valid / trap_target       trap or exception redirect
//   ex_redir_valid / ex_redir_tgt  execute branch-mispredict redirect
//   id_redir_valid / id_redir_tgt  decode jump redirect
//   win                            winning redirect (valid=0 when none)
module redir_arb
  import fetch_ctrl_pkg::*;
(
  input  logic      trap_valid,
  input  u64        trap_target,
  input  logic      ex_redir_valid,
  input  u64        ex_redir_tgt,
  input  logic      id_redir_valid,
  input  u64        id_redir_tgt,
  output redirect_t win
);

  always_comb begin
    win = no_redirect();
    if (trap_valid) begin
      win.valid  = 1'b1;
      win.prio   = TRAP;
      win.target = trap_target;
    end else if (ex_redir_valid) begin
      win.valid  = 1'b1;
      win.prio   = EX;
      win.target = ex_redir_tgt;
    end else if (id_redir_valid) begin
      win.valid  = 1'b1;
      win.prio   = ID;
      win.target = id_redir_tgt;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage PC sequencing, ibus handshake and redirect parking
//
// Purpose: chooses pc_nxt / stallpc for the external PC register, issues one
//          ibus request at a time for the current pc, parks redirects that
//          arrive while a request is outstanding, and holds one returned
//          instruction while decode is stalled.
// Parameters:
//   RESET_PC    must match the PC register reset value
//   INST_BYTES  sequential PC increment
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   pc / pc_nxt / stallpc           PC register interface
//   trap_*, ex_redir_*, id_redir_*  redirect sources
//   ireq_valid / ireq_addr          ibus request
//   iresp_ok / iresp_data           ibus response
//   id_stall                        decode back-pressure
//   if_valid / if_inst              to the IF/ID pipeline register
//   perf_stall_cyc, perf_redirects  only when FETCH_CTRL_PERF_EN is defined
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h8000_0000,
  parameter int          INST_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc,
  output logic [63:0] pc_nxt,
  output logic        stallpc,
  input  logic        trap_valid,
  input  logic [63:0] trap_target,
  input  logic        ex_redir_valid,
  input  logic [63:0] ex_redir_tgt,
  input  logic        id_redir_valid,
  input  logic [63:0] id_redir_tgt,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_ok,
  input  logic [31:0] iresp_data,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_inst
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [63:0] perf_stall_cyc,
  output logic [63:0] perf_redirects
`endif
);

  localparam u64 PC_INC = 64'(INST_BYTES);

  fetch_state_t state, state_nxt;

  logic        pend_valid;
  redir_prio_t pend_prio;
  u64          pend_tgt;
  logic        park;
  logic        pend_clr;

  u32          inst_buf;
  logic        buf_load;

  redirect_t   new_redir;
  redirect_t   eff_redir;

  redir_arb u_redir_arb (
    .trap_valid     (trap_valid),
    .trap_target    (trap_target),
    .ex_redir_valid (ex_redir_valid),
    .ex_redir_tgt   (ex_redir_tgt),
    .id_redir_valid (id_redir_valid),
    .id_redir_tgt   (id_redir_tgt),
    .win            (new_redir)
  );

  // A parked redirect survives unless something strictly more urgent arrives.
  always_comb begin
    eff_redir = new_redir;
    if (pend_valid && (!new_redir.valid || (new_redir.prio <= pend_prio))) begin
      eff_redir.valid  = 1'b1;
      eff_redir.prio   = pend_prio;
      eff_redir.target = pend_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_prio  <= NONE;
      pend_tgt   <= '0;
      inst_buf   <= '0;
    end else begin
      state <= state_nxt;
      if (pend_clr) begin
        pend_valid <= 1'b0;
        pend_prio  <= NONE;
        pend_tgt   <= '0;
      end else if (park) begin
        pend_valid <= 1'b1;
        pend_prio  <= eff_redir.prio;
        pend_tgt   <= eff_redir.target;
      end
      if (buf_load) begin
        inst_buf <= iresp_data;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    stallpc    = 1'b1;
    ireq_valid = 1'b0;
    ireq_addr  = pc;
    if_valid   = 1'b0;
    if_inst    = inst_buf;
    park       = 1'b0;
    pend_clr   = 1'b0;
    buf_load   = 1'b0;

    unique case (state)
      IDLE: begin
        // A late response from an abandoned request lands here and is ignored.
        pc_nxt    = RESET_PC;
        pend_clr  = 1'b1;
        state_nxt = REQ;
      end

      REQ: begin
        ireq_valid = 1'b1;
        if (iresp_ok) begin
          pend_clr = 1'b1;
          if (eff_redir.valid) begin
            // Redirect wins over delivery: returned instruction is wrong-path.
            pc_nxt  = eff_redir.target;
            stallpc = 1'b0;
          end else if (!id_stall) begin
            if_valid = 1'b1;
            if_inst  = iresp_data;
            pc_nxt   = pc + PC_INC;
            stallpc  = 1'b0;
          end else begin
            buf_load  = 1'b1;
            state_nxt = HOLD;
          end
        end else if (eff_redir.valid) begin
          park = 1'b1;
        end
      end

      HOLD: begin
        // Nothing is parked here: HOLD is only entered on a redirect-free return.
        if (new_redir.valid) begin
          pc_nxt    = new_redir.target;
          stallpc   = 1'b0;
          state_nxt = REQ;
        end else begin
          if_valid = 1'b1;
          if (!id_stall) begin
            pc_nxt    = pc + PC_INC;
            stallpc   = 1'b0;
            state_nxt = REQ;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef FETCH_CTRL_PERF_EN
  // Any cycle the PC moves to a redirect target counts as an applied redirect.
  logic redir_apply;
  assign redir_apply = !stallpc && eff_redir.valid && (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cyc <= '0;
      perf_redirects <= '0;
    end else begin
      if (stallpc && (state != IDLE)) begin
        perf_stall_cyc <= perf_stall_cyc + 64'd1;
      end
      if (redir_apply) begin
        perf_redirects <= perf_redirects + 64'd1;
      end
    end
  end
`endif

endmodule
